// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode constants, ALUOp encodings and the per-stage control bundle
// used by the five-stage pipeline control unit.
package pipeline_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

  // Only R-type, store and branch actually read rs2, so only they can hazard on it.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder producing the control bundle for the ID instruction.
import pipeline_ctrl_pkg::*;

module ctrl_decoder #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [6:0]            i_opcode,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output ctrl_t                 o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_BUBBLE;
    case (i_opcode)
      OP_R: begin
        o_ctrl.alu_op    = ALU_FUNCT;
        o_ctrl.reg_write = 1'b1;
      end
      OP_LD: begin
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_SD: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.branch = 1'b1;
      end
      default: o_ctrl = CTRL_BUBBLE;
    endcase
    // x0 is hardwired to zero, so writes to it are suppressed at decode.
    if (i_rd == '0) o_ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control: decode, load-use stall, branch flush, ID/EX->EX/MEM->MEM/WB
// control registers and a saturating load-use stall counter.
import pipeline_ctrl_pkg::*;

module pipeline_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             opcode_id,
  input  logic [REG_ADDR_W-1:0]  rs1_id,
  input  logic [REG_ADDR_W-1:0]  rs2_id,
  input  logic [REG_ADDR_W-1:0]  rd_id,
  input  logic                   branch_taken_ex,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic [1:0]             alu_op_ex,
  output logic                   alu_src_ex,
  output logic                   branch_ex,
  output logic                   mem_read_ex,
  output logic [REG_ADDR_W-1:0]  rd_ex,
  output logic                   mem_read_mem,
  output logic                   mem_write_mem,
  output logic                   mem_to_reg_mem,
  output logic                   reg_write_mem,
  output logic [REG_ADDR_W-1:0]  rd_mem,
  output logic                   mem_to_reg_wb,
  output logic                   reg_write_wb,
  output logic [REG_ADDR_W-1:0]  rd_wb,
  output logic [STALL_CNT_W-1:0] stall_count
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  ctrl_t                  w_ctrl_id;
  ctrl_t                  r_ctrl_ex_p0, r_ctrl_mem_p1, r_ctrl_wb_p2;
  logic [REG_ADDR_W-1:0]  r_rd_ex_p0, r_rd_mem_p1, r_rd_wb_p2;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_stall, w_flush, w_bubble;

  ctrl_decoder #(.REG_ADDR_W(REG_ADDR_W)) u_decoder (
    .i_opcode (opcode_id),
    .i_rd     (rd_id),
    .o_ctrl   (w_ctrl_id)
  );

  assign w_stall = r_ctrl_ex_p0.mem_read && (r_rd_ex_p0 != '0) &&
                   ((r_rd_ex_p0 == rs1_id) || ((r_rd_ex_p0 == rs2_id) && uses_rs2(opcode_id)));
  assign w_flush  = r_ctrl_ex_p0.branch && branch_taken_ex;
  assign w_bubble = w_stall || w_flush;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
    end else if (w_flush) begin
      ifid_flush = 1'b1;
    end else if (w_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_ex_p0  <= CTRL_BUBBLE;
      r_ctrl_mem_p1 <= CTRL_BUBBLE;
      r_ctrl_wb_p2  <= CTRL_BUBBLE;
      r_rd_ex_p0    <= '0;
      r_rd_mem_p1   <= '0;
      r_rd_wb_p2    <= '0;
      r_stall_cnt   <= '0;
    end else begin
      // ID -> EX: a stall or flush injects a bubble in place of the ID instruction
      r_ctrl_ex_p0  <= w_bubble ? CTRL_BUBBLE : w_ctrl_id;
      r_rd_ex_p0    <= w_bubble ? '0 : rd_id;
      // EX -> MEM
      r_ctrl_mem_p1 <= r_ctrl_ex_p0;
      r_rd_mem_p1   <= r_rd_ex_p0;
      // MEM -> WB
      r_ctrl_wb_p2  <= r_ctrl_mem_p1;
      r_rd_wb_p2    <= r_rd_mem_p1;
      if (w_stall && !w_flush) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign alu_op_ex      = r_ctrl_ex_p0.alu_op;
  assign alu_src_ex     = r_ctrl_ex_p0.alu_src;
  assign branch_ex      = r_ctrl_ex_p0.branch;
  assign mem_read_ex    = r_ctrl_ex_p0.mem_read;
  assign rd_ex          = r_rd_ex_p0;
  assign mem_read_mem   = r_ctrl_mem_p1.mem_read;
  assign mem_write_mem  = r_ctrl_mem_p1.mem_write;
  assign mem_to_reg_mem = r_ctrl_mem_p1.mem_to_reg;
  assign reg_write_mem  = r_ctrl_mem_p1.reg_write;
  assign rd_mem         = r_rd_mem_p1;
  assign mem_to_reg_wb  = r_ctrl_wb_p2.mem_to_reg;
  assign reg_write_wb   = r_ctrl_wb_p2.reg_write;
  assign rd_wb          = r_rd_wb_p2;
  assign stall_count    = r_stall_cnt;

  // Fields carried by the shared bundle that later stages no longer consume.
  logic w_unused;
  assign w_unused = ^{r_ctrl_ex_p0.mem_write, r_ctrl_ex_p0.mem_to_reg, r_ctrl_ex_p0.reg_write,
                      r_ctrl_mem_p1.alu_op, r_ctrl_mem_p1.alu_src, r_ctrl_mem_p1.branch,
                      r_ctrl_wb_p2.alu_op, r_ctrl_wb_p2.alu_src, r_ctrl_wb_p2.branch,
                      r_ctrl_wb_p2.mem_read, r_ctrl_wb_p2.mem_write};

endmodule
